twiddle_gen: RTL
================

# twiddle_gen

Parametrised radix-2 FFT twiddle-factor sequencer. Given a stage number, it streams the N/2 complex twiddles W_N^k = cos(2πk/N) − j·sin(2πk/N) that the butterfly datapath consumes for that stage, in butterfly order, over a valid/ready interface. It stores only a quarter-wave cosine table and derives the real and imaginary parts by symmetry. It sits between the FFT stage controller and the butterfly unit of the CWT transform path.

## Interface
- N_LOG2, 5: log2 of FFT size N; legal range 3..10
- DATA_W, 16: twiddle word width, two's complement
- FRAC_W, 8: fractional bits (Q(DATA_W−FRAC_W).FRAC_W); 1.0 = 2^FRAC_W
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request a stage sequence; sampled only in IDLE
- stage  in  $clog2(N_LOG2)  stage index s, 0..N_LOG2−1; sampled with start
- busy  out  1  sequence in progress
- err  out  1  one-cycle pulse: start with stage ≥ N_LOG2
- out_valid  out  1  twiddle present
- out_ready  in  1  consumer accepts
- tw_re  out  DATA_W  cos term
- tw_im  out  DATA_W  −sin term
- last  out  1  qualifies the final twiddle of the sequence

## Operation
- Sequence for stage s: G = 2^(N_LOG2−1−s) groups; within each group j = 0..2^s−1 and k = j << (N_LOG2−1−s). Total is N/2 twiddles, with groups emitted back to back.
- Q = quarter table, Q[m] = round-to-nearest(2^FRAC_W·cos(2πm/N)) for m = 0..N/4 (N/4+1 entries).
- If k < N/4: tw_re = Q[k], tw_im = −Q[N/4−k].
- Otherwise, with k' = k−N/4: tw_re = −Q[N/4−k'], tw_im = −Q[k'].
- Negation is two's complement at DATA_W. −0 gives 0. No saturation is needed.
- FSM states:
  - IDLE: start with a valid stage moves to RUN and sets busy. start with an invalid stage pulses err and stays in IDLE.
  - RUN: issues one index per enabled cycle. After the last index is issued, moves to DRAIN.
  - DRAIN: waits for the handshake on last, then returns to IDLE.
- start in RUN or DRAIN is ignored. No err is raised for it.
- Pipeline: index counter → ROM read register → sign/select output register. The whole pipe advances when !(out_valid && !out_ready).
- Under stall, tw_re, tw_im, last and out_valid hold. No sample is dropped or duplicated.
- last is high only on the N/2-th output.

## Timing
- Reset values: busy=0, err=0, out_valid=0, last=0, tw_re=0, tw_im=0. FSM goes to IDLE and counters clear.
- rst_n low mid-sequence aborts it. Outputs take reset values at the next edge.
- Edge E samples start. busy is high after E. Assuming out_ready stays high, out_valid is high after E+3.
- Throughput is one twiddle per cycle. The final handshake lands at E+3+N/2−1.
- busy falls at the edge following the handshake on last.
- A new start can be sampled at that same edge.
- err is high for exactly the one cycle after E.

## Structure
- Package twiddle_pkg holds:
  - FSM state encoding;
  - a constant function building the Q table from N_LOG2/FRAC_W;
  - the reference Q values for N_LOG2=5, FRAC_W=8: 0x100, 0xFB, 0xED, 0xD5, 0xB5, 0x8E, 0x62, 0x32, 0x000.
- Sub-module twiddle_quarter_rom: synchronous-read table. It has two read ports (m and N/4−m), a read enable, and an address width of N_LOG2−1.
- The top level holds the FSM, the group/index counters, the k decomposition and the sign stage.

## Test plan
Defaults are N_LOG2=5, FRAC_W=8.
- Reset with rst_n low for 2 cycles → all outputs 0. Then start with stage=0 → 16 outputs, each re=0x0100, im=0x0000; last on the 16th; busy drops the edge after.
- Stage 4, out_ready=1:
  - k=0 → 0x0100/0x0000
  - k=4 → 0x00B5/0xFF4B
  - k=8 → 0x0000/0xFF00
  - k=12 → 0xFF4B/0xFF4B
  - k=15 → 0xFF05/0xFFCE
  - first out_valid at E+3.
- Stage 2 → k order 0, 4, 8, 12 repeated 4 times. The values match the stage-4 entries for the same k.
- Stage 4 with out_ready held low for 5 cycles at output #6 → #6 is stable throughout the stall. Exactly 16 handshakes follow, with the same values as the unstalled run.
- The following cases are driven in turn:
  - start with stage=5 → err is a single-cycle pulse; busy stays 0.
  - start again while busy → ignored; the sequence length is unchanged.
  - rst_n low at output #9 → out_valid=0 at the next edge, then a clean restart.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and table builder for the radix-2 FFT twiddle sequencer.
// The quarter-wave cosine table is computed at elaboration from N_LOG2/FRAC_W.
package twiddle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tw_state_e;

  // Known-good table for N_LOG2=5, FRAC_W=8 (entries m = 0..8).
  localparam int REF_N_LOG2 = 5;
  localparam int REF_FRAC_W = 8;
  localparam logic [15:0] REF_Q5 [0:8] = '{
    16'h0100, 16'h00FB, 16'h00ED, 16'h00D5, 16'h00B5,
    16'h008E, 16'h0062, 16'h0032, 16'h0000
  };

  // round(2^frac_w * cos(2*pi*m / 2^n_log2)) for 0 <= m <= N/4; Taylor series keeps it tool-neutral.
  function automatic int q_value(input int n_log2, input int frac_w, input int m);
    real pi;
    real x;
    real term;
    real sum;
    real scale;
    pi    = 3.14159265358979323846;
    x     = 2.0 * pi * real'(m) / real'(1 << n_log2);
    term  = 1.0;
    sum   = 1.0;
    for (int i = 1; i <= 12; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    scale = real'(1 << frac_w);
    // Non-negative over the quarter wave, so +0.5 then truncate is round-to-nearest.
    return $rtoi(sum * scale + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Twiddle output stream: valid/ready handshake carrying one complex twiddle per beat.
interface twiddle_gen_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] tw_re;
  logic [DATA_W-1:0] tw_im;
  logic              last;

  modport master (
    output out_valid,
    output tw_re,
    output tw_im,
    output last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  tw_re,
    input  tw_im,
    input  last,
    output out_ready
  );
endinterface

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table with two synchronous read ports (Q[m] and Q[N/4-m]).
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic [N_LOG2-2:0]   addr_a,
  input  logic [N_LOG2-2:0]   addr_b,
  output logic [DATA_W-1:0]   q_a,
  output logic [DATA_W-1:0]   q_b
);
  localparam int DEPTH = (1 << (N_LOG2 - 2)) + 1;

  logic [DATA_W-1:0] rom_mem [0:DEPTH-1];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign rom_mem[gi] = DATA_W'(q_value(N_LOG2, FRAC_W, gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rd_en) begin
      q_a <= rom_mem[addr_a];
      q_b <= rom_mem[addr_b];
    end
  end
endmodule

// File: rtl/twiddle_gen.sv
// Streams the N/2 twiddles of one radix-2 FFT stage in butterfly order.
// Pipe: index register -> table read register -> sign/select output register.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(N_LOG2)-1:0]   stage,
  output logic                        busy,
  output logic                        err,
  twiddle_gen_if.master               tw
);
  localparam int AW = N_LOG2 - 1;
  localparam int MW = N_LOG2 - 2;
  localparam int SW = $clog2(N_LOG2);
  localparam logic [AW-1:0] QUARTER   = AW'(1 << MW);
  localparam logic [SW:0]   STAGE_LIM = (SW + 1)'(N_LOG2);

  tw_state_e         state_reg;
  logic [SW-1:0]     stage_reg;
  logic [AW-1:0]     j_reg;
  logic [AW-1:0]     grp_reg;
  logic              busy_reg;
  logic              err_reg;

  logic              v0_reg;
  logic              last0_reg;
  logic [AW-1:0]     k_reg;
  logic              v1_reg;
  logic              last1_reg;
  logic              quad1_reg;
  logic              out_valid_reg;
  logic              last_reg;
  logic [DATA_W-1:0] re_reg;
  logic [DATA_W-1:0] im_reg;

  logic [AW-1:0]     j_max;
  logic [AW-1:0]     grp_max;
  logic [SW-1:0]     shamt;
  logic [AW-1:0]     k_cur;
  logic [AW-1:0]     m_a;
  logic [AW-1:0]     m_b;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;
  logic [DATA_W-1:0] re_next;
  logic [DATA_W-1:0] im_next;
  logic              adv;
  logic              running;
  logic              final_idx;
  logic              done_hs;
  logic              stage_ok;

  // Stage s: 2^s twiddles per group with stride 2^(N_LOG2-1-s), 2^(N_LOG2-1-s) groups.
  assign shamt     = SW'(AW) - stage_reg;
  assign j_max     = AW'((32'd1 << stage_reg) - 32'd1);
  assign grp_max   = AW'((32'd1 << shamt) - 32'd1);
  assign k_cur     = j_reg << shamt;
  assign final_idx = (j_reg == j_max) && (grp_reg == grp_max);

  assign adv       = !(out_valid_reg && !tw.out_ready);
  assign running   = (state_reg == ST_RUN);
  assign done_hs   = out_valid_reg && tw.out_ready && last_reg;
  assign stage_ok  = ({1'b0, stage} < STAGE_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      stage_reg <= '0;
      j_reg     <= '0;
      grp_reg   <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (stage_ok) begin
              state_reg <= ST_RUN;
              stage_reg <= stage;
              j_reg     <= '0;
              grp_reg   <= '0;
              busy_reg  <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (adv) begin
            if (final_idx) begin
              state_reg <= ST_DRAIN;
            end else if (j_reg == j_max) begin
              j_reg   <= '0;
              grp_reg <= grp_reg + 1'b1;
            end else begin
              j_reg <= j_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The edge that retires the last twiddle may also accept the next start.
          if (done_hs) begin
            if (start && stage_ok) begin
              state_reg <= ST_RUN;
              stage_reg <= stage;
              j_reg     <= '0;
              grp_reg   <= '0;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              err_reg   <= start;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Both halves of the wave use Q[m] and Q[N/4-m]; only the sign/swap differs.
  assign m_a = {1'b0, k_reg[MW-1:0]};
  assign m_b = QUARTER - m_a;

  twiddle_quarter_rom #(
    .N_LOG2 (N_LOG2),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_rom (
    .clk    (clk),
    .rd_en  (adv),
    .addr_a (m_a),
    .addr_b (m_b),
    .q_a    (q_a),
    .q_b    (q_b)
  );

  always_comb begin
    re_next = '0;
    im_next = '0;
    if (v1_reg) begin
      if (quad1_reg) begin
        re_next = -q_b;
        im_next = -q_a;
      end else begin
        re_next = q_a;
        im_next = -q_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_reg        <= 1'b0;
      last0_reg     <= 1'b0;
      k_reg         <= '0;
      v1_reg        <= 1'b0;
      last1_reg     <= 1'b0;
      quad1_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      re_reg        <= '0;
      im_reg        <= '0;
    end else if (adv) begin
      v0_reg        <= running;
      last0_reg     <= running && final_idx;
      k_reg         <= k_cur;
      v1_reg        <= v0_reg;
      last1_reg     <= v0_reg && last0_reg;
      quad1_reg     <= k_reg[MW];
      out_valid_reg <= v1_reg;
      last_reg      <= v1_reg && last1_reg;
      re_reg        <= re_next;
      im_reg        <= im_next;
    end
  end

  assign busy         = busy_reg;
  assign err          = err_reg;
  assign tw.out_valid = out_valid_reg;
  assign tw.last      = last_reg;
  assign tw.tw_re     = re_reg;
  assign tw.tw_im     = im_reg;
endmodule
